// File: rtl/toggle_period_monitor_if.sv
// Toggle period monitor bus: observed input, controls and status.
// The monitor is the slave; whoever drives sig_in/enable/clear is the master.
interface toggle_period_monitor_if #(
  parameter int CNT_W = 16
);
  logic             sig_in;
  logic             enable;
  logic             clear;
  logic             toggle_pulse;
  logic [CNT_W-1:0] edge_count;
  logic [CNT_W-1:0] last_period;
  logic             period_valid;
  logic             stall;
  logic [1:0]       state;

  modport master (
    output sig_in, enable, clear,
    input  toggle_pulse, edge_count, last_period,
    input  period_valid, stall, state
  );

  modport slave (
    input  sig_in, enable, clear,
    output toggle_pulse, edge_count, last_period,
    output period_valid, stall, state
  );
endinterface

// File: rtl/toggle_period_monitor.sv
// Synchronizes a toggling input, counts its transitions, measures the
// spacing between them and flags a stall when it stops toggling.
module toggle_period_monitor #(
  parameter int CNT_W       = 16,
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT     = 1000
) (
  input logic                   clk,
  input logic                   rst_n,
  toggle_period_monitor_if.slave bus
);
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARM     = 2'd1,
    MEASURE = 2'd2,
    STALL   = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] MAX = '1;
  localparam logic [31:0] TO = 32'(TIMEOUT);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_prev;
  logic                   r_toggle;
  state_t                 r_state;
  logic [CNT_W-1:0]       r_count;
  logic [CNT_W-1:0]       r_period;
  logic [CNT_W-1:0]       r_gap;
  logic                   r_valid;
  logic                   r_stall;

  logic                   w_edge;
  logic [CNT_W-1:0]       w_count_inc;
  logic [CNT_W-1:0]       w_gap_inc;
  logic                   w_timeout;

  assign w_edge      = r_sync[SYNC_STAGES-1] ^ r_prev;
  assign w_count_inc = (r_count == MAX) ? r_count : r_count + 1'b1;
  assign w_gap_inc   = (r_gap == MAX) ? r_gap : r_gap + 1'b1;
  assign w_timeout   = 32'(w_gap_inc) >= TO;

  // Runs regardless of enable so enabling never sees a stale edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync   <= '0;
      r_prev   <= 1'b0;
      r_toggle <= 1'b0;
    end else begin
      r_sync   <= {r_sync[SYNC_STAGES-2:0], bus.sig_in};
      r_prev   <= r_sync[SYNC_STAGES-1];
      r_toggle <= w_edge;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_count  <= '0;
      r_period <= '0;
      r_gap    <= '0;
      r_valid  <= 1'b0;
      r_stall  <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      if (bus.clear) begin
        r_count  <= '0;
        r_period <= '0;
        r_gap    <= '0;
        r_stall  <= 1'b0;
        r_state  <= bus.enable ? ARM : IDLE;
      end else if (!bus.enable) begin
        r_stall <= 1'b0;
        r_state <= IDLE;
      end else begin
        unique case (r_state)
          IDLE: r_state <= ARM;
          ARM: begin
            if (w_edge) begin
              r_count <= w_count_inc;
              r_gap   <= '0;
              r_state <= MEASURE;
            end
          end
          MEASURE: begin
            if (w_edge) begin
              r_period <= w_gap_inc;
              r_valid  <= 1'b1;
              r_count  <= w_count_inc;
              r_gap    <= '0;
            end else if (w_timeout) begin
              r_stall <= 1'b1;
              r_state <= STALL;
            end else begin
              r_gap <= w_gap_inc;
            end
          end
          STALL: begin
            // A stalled interval is not a period; resume measuring.
            if (w_edge) begin
              r_stall <= 1'b0;
              r_count <= w_count_inc;
              r_gap   <= '0;
              r_state <= MEASURE;
            end
          end
        endcase
      end
    end
  end

  assign bus.toggle_pulse = r_toggle;
  assign bus.edge_count   = r_count;
  assign bus.last_period  = r_period;
  assign bus.period_valid = r_valid;
  assign bus.stall        = r_stall;
  assign bus.state        = r_state;
endmodule

// File: tb/tb_toggle_period_monitor.sv
// Randomized bench for toggle_period_monitor: two configurations
// share one stimulus and are compared each cycle to a timestamp model.
module tb_toggle_period_monitor;
  logic clk;
  logic rst_n;
  logic r_sig;
  logic r_en;
  logic r_clr;

  toggle_period_monitor_if #(.CNT_W(16)) if_a ();
  toggle_period_monitor_if #(.CNT_W(4))  if_b ();

  assign if_a.sig_in = r_sig;
  assign if_a.enable = r_en;
  assign if_a.clear  = r_clr;
  assign if_b.sig_in = r_sig;
  assign if_b.enable = r_en;
  assign if_b.clear  = r_clr;

  toggle_period_monitor #(
    .CNT_W(16), .SYNC_STAGES(2), .TIMEOUT(8)
  ) u_a (
    .clk(clk), .rst_n(rst_n), .bus(if_a)
  );

  toggle_period_monitor #(
    .CNT_W(4), .SYNC_STAGES(3), .TIMEOUT(30)
  ) u_b (
    .clk(clk), .rst_n(rst_n), .bus(if_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int t = 0;

  int SY[2]   = '{2, 3};
  int TOV[2]  = '{8, 30};
  int MAXV[2] = '{65535, 15};

  // sampled input history, hist[0] is the newest edge's sample
  int hist[8];
  int m_tp[2], m_pv[2], m_stall[2];
  int m_cnt[2], m_lp[2], m_st[2], m_last[2];

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)",
               tag, got, exp, t);
    end
  endtask

  function automatic int min2(int a, int b);
    return (a < b) ? a : b;
  endfunction

  task automatic model_reset();
    foreach (hist[k]) hist[k] = 0;
    for (int i = 0; i < 2; i++) begin
      m_tp[i] = 0; m_pv[i] = 0; m_stall[i] = 0;
      m_cnt[i] = 0; m_lp[i] = 0; m_st[i] = 0; m_last[i] = 0;
    end
  endtask

  task automatic model_step();
    int det;
    t++;
    for (int k = 7; k > 0; k--) hist[k] = hist[k-1];
    hist[0] = int'(r_sig);
    for (int i = 0; i < 2; i++) begin
      det = hist[SY[i]] ^ hist[SY[i]+1];
      m_tp[i] = det;
      m_pv[i] = 0;
      if (r_clr) begin
        m_cnt[i] = 0; m_lp[i] = 0; m_stall[i] = 0;
        m_st[i] = r_en ? 1 : 0;
      end else if (!r_en) begin
        m_st[i] = 0; m_stall[i] = 0;
      end else if (m_st[i] == 0) begin
        m_st[i] = 1;
      end else if (det != 0) begin
        m_cnt[i] = min2(m_cnt[i] + 1, MAXV[i]);
        if (m_st[i] == 2) begin
          m_lp[i] = min2(t - m_last[i], MAXV[i]);
          m_pv[i] = 1;
        end
        m_st[i] = 2; m_stall[i] = 0; m_last[i] = t;
      end else if (m_st[i] == 2 &&
                   min2(t - m_last[i], MAXV[i]) >= TOV[i]) begin
        m_st[i] = 3; m_stall[i] = 1;
      end
    end
  endtask

  task automatic check_all();
    check("A.toggle", 32'(if_a.toggle_pulse), 32'(m_tp[0]));
    check("A.count",  32'(if_a.edge_count),   32'(m_cnt[0]));
    check("A.period", 32'(if_a.last_period),  32'(m_lp[0]));
    check("A.valid",  32'(if_a.period_valid), 32'(m_pv[0]));
    check("A.stall",  32'(if_a.stall),        32'(m_stall[0]));
    check("A.state",  32'(if_a.state),        32'(m_st[0]));
    check("B.toggle", 32'(if_b.toggle_pulse), 32'(m_tp[1]));
    check("B.count",  32'(if_b.edge_count),   32'(m_cnt[1]));
    check("B.period", 32'(if_b.last_period),  32'(m_lp[1]));
    check("B.valid",  32'(if_b.period_valid), 32'(m_pv[1]));
    check("B.stall",  32'(if_b.stall),        32'(m_stall[1]));
    check("B.state",  32'(if_b.state),        32'(m_st[1]));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (!rst_n) model_reset();
    else model_step();
    check_all();
  endtask

  task automatic toggle_n(input int per, input int n);
    repeat (n) begin
      r_sig = ~r_sig;
      repeat (per) tick();
    end
  endtask

  initial begin
    int per;
    int n;
    rst_n = 1'b0;
    r_sig = 1'b0;
    r_en  = 1'b0;
    r_clr = 1'b0;
    model_reset();
    repeat (3) tick();
    rst_n = 1'b1;
    r_en  = 1'b1;

    toggle_n(4, 10);
    check("stream.count", 32'(if_a.edge_count), 32'd10);
    check("stream.period", 32'(if_a.last_period), 32'd4);
    repeat (14) tick();
    check("hold.stall", 32'(if_a.stall), 32'd1);
    check("hold.state", 32'(if_a.state), 32'd3);
    toggle_n(6, 1);
    check("resume.count", 32'(if_a.edge_count), 32'd11);
    check("resume.period", 32'(if_a.last_period), 32'd4);
    check("resume.stall", 32'(if_a.stall), 32'd0);

    toggle_n(2, 6);
    toggle_n(6, 4);
    toggle_n(8, 3);
    check("edge8.stall", 32'(if_a.stall), 32'd0);
    check("edge8.period", 32'(if_a.last_period), 32'd8);
    toggle_n(1, 20);
    repeat (20) tick();
    toggle_n(5, 1);
    check("sat.count", 32'(if_b.edge_count), 32'd15);
    check("sat.period", 32'(if_b.last_period), 32'd15);

    // clear landing on the same edge as a detection in config A
    repeat (3) begin
      toggle_n(4, 5);
      r_sig = ~r_sig;
      for (int k = 0; k < 8; k++) begin
        if ((hist[SY[0]-1] ^ hist[SY[0]]) != 0) break;
        tick();
      end
      r_clr = 1'b1;
      tick();
      r_clr = 1'b0;
      check("clr.toggle", 32'(if_a.toggle_pulse), 32'd1);
      check("clr.count", 32'(if_a.edge_count), 32'd0);
      check("clr.state", 32'(if_a.state), 32'd1);
      toggle_n(4, 1);
      check("clr.next", 32'(if_a.edge_count), 32'd1);
    end

    repeat (40) begin
      per = $urandom_range(1, 11);
      n   = $urandom_range(1, 5);
      repeat (n) begin
        r_sig = ~r_sig;
        r_clr = ($urandom_range(0, 29) == 0);
        r_en  = ($urandom_range(0, 19) != 0);
        repeat (per) begin
          tick();
          r_clr = 1'b0;
        end
      end
    end
    r_en = 1'b1;

    // asynchronous reset mid-measurement with sig_in high
    r_sig = 1'b0;
    toggle_n(4, 4);
    r_sig = 1'b1;
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_all();
    repeat (3) tick();
    rst_n = 1'b1;
    repeat (10) tick();
    check("rst.count", 32'(if_a.edge_count), 32'd1);
    check("rst.countb", 32'(if_b.edge_count), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_errors);
    $finish;
  end
endmodule
